// File: rtl/fir_err_pkg.sv
// Shared widths and FSM encoding for the approximate-vs-exact FIR error meter.
package fir_err_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LOG2_WIN = 10;
    localparam int ERR_W        = DEF_DATA_W + 1;
    localparam int SUM_W        = ERR_W + DEF_LOG2_WIN;

    typedef enum logic [0:0] {
        S_WARM = 1'b0,
        S_ACC  = 1'b1
    } state_e;

    function automatic int calc_err_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int calc_sum_w(input int data_w, input int log2_win);
        return calc_err_w(data_w) + log2_win;
    endfunction

endpackage

// File: rtl/fir_abs_diff.sv
// Combinational |a - b| with one bit of headroom, so full-scale operands cannot overflow.
module fir_abs_diff
    import fir_err_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic signed [DATA_W-1:0]             a_i,
    input  logic signed [DATA_W-1:0]             b_i,
    output logic        [calc_err_w(DATA_W)-1:0] abs_o
);

    localparam int ERR_WIDTH = calc_err_w(DATA_W);

    logic signed [ERR_WIDTH-1:0] diff;

    always_comb begin
        diff  = ERR_WIDTH'(a_i) - ERR_WIDTH'(b_i);
        abs_o = diff[ERR_WIDTH-1] ? $unsigned(-diff) : $unsigned(diff);
    end

endmodule

// File: rtl/fir_err_accum.sv
// Windowed error statistics (mean/max/non-zero count) between an approximate and an exact FIR.
module fir_err_accum
    import fir_err_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WARMUP   = 15,
    parameter int LOG2_WIN = 10
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] Data_approx,
    input  logic signed [DATA_W-1:0] Data_exact,
    output logic        [DATA_W:0]   mae,
    output logic        [DATA_W:0]   max_err,
    output logic        [LOG2_WIN:0] err_count,
    output logic        [15:0]       win_count,
    output logic                     result_valid
);

    localparam int ERR_WIDTH = calc_err_w(DATA_W);
    localparam int SUM_WIDTH = calc_sum_w(DATA_W, LOG2_WIN);
    localparam int CNT_WIDTH = LOG2_WIN + 1;
    localparam int WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [WARM_W-1:0]   WARM_LAST  = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [LOG2_WIN-1:0] LAST_IDX   = '1;
    localparam state_e              INIT_STATE = (WARMUP == 0) ? S_ACC : S_WARM;

    function automatic logic [ERR_WIDTH-1:0] mean_trunc(input logic [SUM_WIDTH-1:0] s);
        return ERR_WIDTH'(s >> LOG2_WIN);
    endfunction

    function automatic logic [ERR_WIDTH-1:0] max_of(input logic [ERR_WIDTH-1:0] a,
                                                    input logic [ERR_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [ERR_WIDTH-1:0] abs_err_c;

    logic [ERR_WIDTH-1:0] abs_err_p1_q, abs_err_p1_d;
    logic                 vld_p1_q, vld_p1_d;

    state_e               state_q, state_d;
    logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic [LOG2_WIN-1:0]  idx_q, idx_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d, sum_new;
    logic [ERR_WIDTH-1:0] wmax_q, wmax_d, wmax_new;
    logic [CNT_WIDTH-1:0] nz_q, nz_d, nz_new;

    logic [ERR_WIDTH-1:0] mae_q, mae_d;
    logic [ERR_WIDTH-1:0] max_err_q, max_err_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [15:0]          win_q, win_d;
    logic                 rv_q, rv_d;

    fir_abs_diff #(
        .DATA_W (DATA_W)
    ) u_abs_diff (
        .a_i   (Data_approx),
        .b_i   (Data_exact),
        .abs_o (abs_err_c)
    );

    always_comb begin
        // stage p1: capture |error| of the incoming sample
        vld_p1_d     = sample_valid;
        abs_err_p1_d = sample_valid ? abs_err_c : abs_err_p1_q;

        // stage p2: fold the registered error into the window
        sum_new  = sum_q + SUM_WIDTH'(abs_err_p1_q);
        wmax_new = max_of(wmax_q, abs_err_p1_q);
        nz_new   = nz_q + CNT_WIDTH'(abs_err_p1_q != '0);

        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        wmax_d      = wmax_q;
        nz_d        = nz_q;
        mae_d       = mae_q;
        max_err_d   = max_err_q;
        err_count_d = err_count_q;
        win_d       = win_q;
        rv_d        = 1'b0;

        if (Clear) begin
            vld_p1_d     = 1'b0;
            abs_err_p1_d = '0;
            state_d      = INIT_STATE;
            warm_cnt_d   = '0;
            idx_d        = '0;
            sum_d        = '0;
            wmax_d       = '0;
            nz_d         = '0;
            win_d        = '0;
        end else if (vld_p1_q) begin
            if (state_q == S_WARM) begin
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = S_ACC;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end else if (idx_q == LAST_IDX) begin
                // Publish including this last sample; next window starts from zero.
                mae_d       = mean_trunc(sum_new);
                max_err_d   = wmax_new;
                err_count_d = nz_new;
                win_d       = win_q + 16'd1;
                rv_d        = 1'b1;
                idx_d       = '0;
                sum_d       = '0;
                wmax_d      = '0;
                nz_d        = '0;
            end else begin
                idx_d  = idx_q + LOG2_WIN'(1);
                sum_d  = sum_new;
                wmax_d = wmax_new;
                nz_d   = nz_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            abs_err_p1_q <= '0;
            vld_p1_q     <= 1'b0;
            state_q      <= INIT_STATE;
            warm_cnt_q   <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            wmax_q       <= '0;
            nz_q         <= '0;
            mae_q        <= '0;
            max_err_q    <= '0;
            err_count_q  <= '0;
            win_q        <= '0;
            rv_q         <= 1'b0;
        end else begin
            abs_err_p1_q <= abs_err_p1_d;
            vld_p1_q     <= vld_p1_d;
            state_q      <= state_d;
            warm_cnt_q   <= warm_cnt_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            wmax_q       <= wmax_d;
            nz_q         <= nz_d;
            mae_q        <= mae_d;
            max_err_q    <= max_err_d;
            err_count_q  <= err_count_d;
            win_q        <= win_d;
            rv_q         <= rv_d;
        end
    end

    assign mae          = mae_q;
    assign max_err      = max_err_q;
    assign err_count    = err_count_q;
    assign win_count    = win_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_fir_err_accum.sv
// Directed bench for fir_err_accum with a queue-based window model and hand-computed pins.
module tb_fir_err_accum;

    localparam int DW = 32;
    localparam int WU = 3;
    localparam int LW = 2;

    logic               clk = 1'b0;
    logic               Reset, Clear, sample_valid;
    logic signed [31:0] Data_approx, Data_exact;
    logic [32:0]        mae, max_err;
    logic [2:0]         err_count;
    logic [15:0]        win_count;
    logic               result_valid;

    fir_err_accum #(
        .DATA_W   (DW),
        .WARMUP   (WU),
        .LOG2_WIN (LW)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Clear        (Clear),
        .sample_valid (sample_valid),
        .Data_approx  (Data_approx),
        .Data_exact   (Data_exact),
        .mae          (mae),
        .max_err      (max_err),
        .err_count    (err_count),
        .win_count    (win_count),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int  vec   = 0;
    int  fails = 0;
    int  n     = 0;
    bit  armed = 0;

    // model state: expected outputs after the most recent edge
    longint m_mae, m_max, m_errc, m_win;
    bit     m_rv;
    int     m_warm;
    longint win_q[$];
    bit     pend_v;
    longint pend_e;

    int pulses = 0;
    int last_pulse_n = -1;
    int prev_pulse_n = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_edge(input bit rst, input bit clr, input bit v,
                              input logic signed [31:0] a, input logic signed [31:0] e);
        longint d, s, mx, nz;
        if (rst) begin
            m_mae = 0; m_max = 0; m_errc = 0; m_win = 0; m_rv = 0;
            m_warm = 0; win_q.delete(); pend_v = 0;
        end else if (clr) begin
            m_rv = 0; m_win = 0; m_warm = 0; win_q.delete(); pend_v = 0;
        end else begin
            m_rv = 0;
            if (pend_v) begin
                if (m_warm < WU) m_warm++;
                else begin
                    win_q.push_back(pend_e);
                    if (win_q.size() == (1 << LW)) begin
                        s = 0; mx = 0; nz = 0;
                        foreach (win_q[i]) begin
                            s += win_q[i];
                            if (win_q[i] > mx) mx = win_q[i];
                            if (win_q[i] != 0) nz++;
                        end
                        m_mae  = s / (1 << LW);
                        m_max  = mx;
                        m_errc = nz;
                        m_win  = (m_win + 1) % 65536;
                        m_rv   = 1;
                        win_q.delete();
                    end
                end
            end
            d      = longint'(a) - longint'(e);
            pend_v = v;
            pend_e = (d < 0) ? -d : d;
        end
    endtask

    task automatic step(input bit rst, input bit clr, input bit v,
                        input logic signed [31:0] a, input logic signed [31:0] e);
        Reset = rst; Clear = clr; sample_valid = v; Data_approx = a; Data_exact = e;
        @(posedge clk);
        n++;
        model_edge(rst, clr, v, a, e);
        #1;
    endtask

    task automatic samp(input logic signed [31:0] a, input logic signed [31:0] e);
        step(0, 0, 1, a, e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 32'sd0, 32'sd0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 32'sd0, 32'sd0);
        step(1, 0, 0, 32'sd0, 32'sd0);
        pulses = 0;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("result_valid", result_valid, m_rv);
            chk("mae", mae, m_mae);
            chk("max_err", max_err, m_max);
            chk("err_count", err_count, m_errc);
            chk("win_count", win_count, m_win);
            if (result_valid) begin
                pulses++;
                prev_pulse_n = last_pulse_n;
                last_pulse_n = n;
            end
        end
    end

    initial begin
        int last_s;
        do_reset();
        armed = 1;
        chk("reset_mae", mae, 0);
        chk("reset_win", win_count, 0);
        chk("reset_rv", result_valid, 0);

        // identical streams
        for (int i = 0; i < 7; i++) samp(32'sd123 * i - 32'sd50, 32'sd123 * i - 32'sd50);
        idle(4);
        chk("ident_pulses", pulses, 1);
        chk("ident_mae", mae, 0);
        chk("ident_max", max_err, 0);
        chk("ident_errc", err_count, 0);
        chk("ident_win", win_count, 1);

        // warm-up errors are discarded
        do_reset();
        for (int i = 0; i < 3; i++) samp(32'sd1100 + i, 32'sd1000 + i);
        for (int i = 0; i < 4; i++) samp(-32'sd20 + i, -32'sd25 + i);
        idle(4);
        chk("warm_mae", mae, 5);
        chk("warm_max", max_err, 5);
        chk("warm_errc", err_count, 4);

        // gaps between window samples
        do_reset();
        for (int i = 0; i < 3; i++) samp(32'sd7, 32'sd7);
        samp(32'sd11, 32'sd10); idle(2);
        samp(32'sd4, 32'sd4);   idle(2);
        samp(32'sd3, 32'sd10);  idle(2);
        samp(-32'sd9, -32'sd9);
        last_s = n;
        idle(4);
        chk("gap_mae", mae, 2);
        chk("gap_max", max_err, 7);
        chk("gap_errc", err_count, 2);
        chk("gap_latency", last_pulse_n, last_s + 1);

        // full-scale difference
        do_reset();
        for (int i = 0; i < 3; i++) samp(32'sd0, 32'sd0);
        samp(32'sh7FFFFFFF, 32'sh80000000);
        for (int i = 0; i < 3; i++) samp(32'sd77, 32'sd77);
        idle(4);
        chk("fs_max", max_err, 33'h0FFFFFFFF);
        chk("fs_mae", mae, 33'h03FFFFFFF);
        chk("fs_errc", err_count, 1);

        // Clear mid-window, coinciding with a valid sample
        do_reset();
        for (int i = 0; i < 3; i++) samp(32'sd1, 32'sd1);
        samp(32'sd9, 32'sd0);
        samp(32'sd9, 32'sd0);
        step(0, 1, 1, 32'sd20, 32'sd0);
        chk("clr_rv", result_valid, 0);
        for (int i = 0; i < 3; i++) samp(32'sd50, 32'sd0);
        for (int i = 0; i < 3; i++) samp(32'sd3, 32'sd0);
        idle(3);
        chk("clr_nopulse_yet", pulses, 0);
        samp(32'sd0, 32'sd3);
        idle(3);
        chk("clr_pulses", pulses, 1);
        chk("clr_win", win_count, 1);
        chk("clr_mae", mae, 3);
        chk("clr_max", max_err, 3);

        // back-to-back windows
        do_reset();
        for (int i = 0; i < 3; i++) samp(32'sd5, 32'sd5);
        for (int i = 1; i <= 8; i++) samp(32'sd1000 + i, 32'sd1000);
        idle(4);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_spacing", last_pulse_n - prev_pulse_n, 4);
        chk("b2b_win", win_count, 2);
        chk("b2b_mae", mae, 6);
        chk("b2b_max", max_err, 8);

        // Reset mid-window discards the partial window
        for (int i = 0; i < 3; i++) samp(32'sd2, 32'sd0);
        step(1, 0, 0, 32'sd0, 32'sd0);
        idle(4);
        chk("midrst_pulses", pulses, 2);
        chk("midrst_mae", mae, 0);
        chk("midrst_win", win_count, 0);

        armed = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule
